gauss3x3_stream: RTL and testbench
==================================

Name: gauss3x3_stream

Overview:
- Streaming 3x3 Gaussian blur (weights 1-2-1 / 2-4-2 / 1-2-1, divide by 16) on raster-order AXI-Stream video.
- Parametrised in frame size, channel count and component width.
- Two internal line buffers: one pixel accepted per cycle under backpressure, no frame-level buffering.
- Adds frame/line markers (tuser/tlast) and a run-time bypass mode.
- Sits between the pixel DMA input stream and downstream filters.

Parameters:
- IMG_W, 640: pixels per input line (>=3).
- IMG_H, 480: lines per input frame (>=3).
- CH, 3: colour channels per pixel. Channel k occupies tdata[k*PW +: PW]; channel CH-1 is the MSBs.
- PW, 8: bits per channel component.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = bypass, 1 = blur. Sampled only at start-of-frame beat.
- s_axis_tdata  in  CH*PW  input pixel.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tuser  in  1  start-of-frame: first pixel of a frame.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  CH*PW  output pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tuser  out  1  first output pixel of a frame.
- m_axis_tlast  out  1  last output pixel of a line.
- m_axis_tready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse when the last output beat of a frame is accepted.
- sof_err  out  1  sticky; set when s_axis_tuser arrives at position other than (0,0); cleared by rst.

Behaviour:
- Reset: all m_axis_* = 0, s_axis_tready = 0 during rst and 1 the cycle after, frame_done = 0, sof_err = 0, row/col counters = 0, active mode = blur. Line-buffer contents are don't-care.
- Handshake: a beat transfers when valid && ready.
- Pipeline is 2 stages:
  - S1: window/line-buffer update.
  - S2: output register.
  - adv = !m_axis_tvalid || m_axis_tready; s_axis_tready = adv.
  - m_axis_tvalid must not drop while a beat is stalled, and m_axis_tdata/tuser/tlast stay stable while stalled.
- Latency: an accepted input beat that produces output appears on m_axis exactly 2 cycles later when not stalled.
- Counters: col counts 0..IMG_W-1, row counts 0..IMG_H-1, both advancing on accepted beats.
  - col wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 to 0 (frame end).
- s_axis_tuser at an accepted beat:
  - forces that pixel to position (0,0) and latches mode;
  - sets sof_err if the counters were not at (0,0).
- Line buffers: two depth-IMG_W, width CH*PW memories, read-before-write at address col. The 3x3 window shifts one column per accepted beat.
- Blur mode:
  - Accepting pixel (r,c) with r>=2 and c>=2 emits output for centre (r-1,c-1).
  - Output frame is (IMG_W-2) x (IMG_H-2); border pixels are cropped, no padding.
  - m_axis_tuser = 1 for centre (1,1).
  - m_axis_tlast = 1 for centre column IMG_W-2.
  - Beats with r<2 or c<2 are accepted and consumed with no output.
- Bypass mode: every accepted beat is output unchanged with the same 2-cycle latency. tuser is forwarded; tlast = (col==IMG_W-1). Line buffers are still written.
- Arithmetic, per channel:
  - sum = Σ w·p, PW+4 bits unsigned.
  - out = (sum + 8) >> 4, round half up.
  - The maximum result is 2^PW-1, so no saturation logic exists.
- frame_done pulses on acceptance of the output beat for the last centre (IMG_H-2, IMG_W-2), or in bypass for pixel (IMG_H-1, IMG_W-1).
- Mode change mid-frame has no effect until the next tuser beat.
- Reset mid-frame discards the pipeline (m_axis_tvalid = 0 next cycle). The next frame must start with tuser.
- Input stall (tvalid = 0) with a full S2: S2 is held until drained; there are no bubbles on the output beyond input gaps.

Decomposition:
- Package gauss_pkg:
  - weight constants;
  - ROUND = 8, SHIFT = 4;
  - enum mode_e {MODE_BYPASS, MODE_BLUR};
  - function clog2-based counter widths.
- Sub-module gauss3x3_kernel (one channel, combinational, PW parameter): nine PW-bit inputs in, rounded PW-bit result out. Instantiated CH times by generate.

Test Plan:
- IMG_W=IMG_H=4, constant 100 every channel, m_tready = 1 -> four outputs all 100; tuser on the first; tlast on the 2nd and 4th; one frame_done pulse.
- 5x5 zeros with 255 at (2,2) -> 3x3 output: centre 64; edge neighbours 32; corners 16.
- Same as the previous scenario, with m_tready low for 5 cycles mid-frame -> s_tready low in the same cycles; output values and order identical to the unstalled run; no lost or duplicated beats.
- mode = 0 at tuser, ramp input 0..15 -> 16 identical outputs 2 cycles after each accept; tlast every 4th beat.
- tuser injected at position (1,2) -> sof_err = 1; counters restart; subsequent full frame is filtered correctly.
- rst asserted mid-frame for 1 cycle -> m_tvalid = 0 next cycle; following frame produces correct outputs.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared constants, types and helpers for the streaming 3x3 Gaussian blur.
package gauss_pkg;

  localparam int W_OUTER = 1;
  localparam int W_INNER = 2;
  localparam int ROUND   = 8;
  localparam int SHIFT   = 4;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_BLUR   = 1'b1
  } mode_e;

  typedef struct packed {
    logic  sof;
    logic  eol;
    logic  eof;
    mode_e mode;
  } beat_meta_t;

  // Separable 1-2-1 taps: row weight times column weight gives 1/2/4.
  function automatic int tap_w(input int r, input int c);
    return ((r == 1) ? W_INNER : W_OUTER) * ((c == 1) ? W_INNER : W_OUTER);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gauss3x3_kernel.sv
// One-channel 3x3 Gaussian: weighted sum of the window, rounded half up, divided by 16.
module gauss3x3_kernel
  import gauss_pkg::*;
#(
  parameter int PW = 8
)(
  input  logic [2:0][2:0][PW-1:0] i_win,
  output logic [PW-1:0]           o_pix
);

  localparam int SW = PW + 4;

  logic [SW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_sum = w_sum + SW'(i_win[r][c]) * SW'(tap_w(r, c));
  end

  // 16*(2^PW-1)+8 still fits SW bits, so no saturation is needed.
  assign o_pix = PW'((w_sum + SW'(ROUND)) >> SHIFT);

endmodule

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian blur on raster AXI-Stream video with bypass mode.
module gauss3x3_stream
  import gauss_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CH    = 3,
  parameter int PW    = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [CH*PW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [CH*PW-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             frame_done,
  output logic             sof_err
);

  localparam int DW = CH * PW;
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic          w_col_last, w_row_last;
  logic          w_adv, w_acc, w_emit;
  mode_e         r_mode, w_mode;
  beat_meta_t    w_meta;
  logic          r_sof_err;

  logic [DW-1:0] r_lb0 [IMG_W];
  logic [DW-1:0] r_lb1 [IMG_W];
  logic [2:0][2:0][DW-1:0] r_win;

  logic          r_s1_vld;
  beat_meta_t    r_s1_meta;
  logic          r_m_valid, r_m_tuser, r_m_tlast, r_m_eof;
  logic [DW-1:0] r_m_tdata;
  logic [CH-1:0][PW-1:0] w_blur;

  assign w_adv = !r_m_valid || m_axis_tready;
  assign w_acc = s_axis_tvalid && s_axis_tready;

  // A start-of-frame beat is always pixel (0,0) and carries the new mode.
  assign w_col      = s_axis_tuser ? '0 : r_col;
  assign w_row      = s_axis_tuser ? '0 : r_row;
  assign w_mode     = s_axis_tuser ? mode_e'(mode) : r_mode;
  assign w_col_last = (w_col == COL_LAST);
  assign w_row_last = (w_row == ROW_LAST);
  assign w_emit     = (w_mode == MODE_BYPASS) || (w_row >= RW'(2) && w_col >= CW'(2));

  always_comb begin
    w_meta.sof  = (w_mode == MODE_BYPASS) ? s_axis_tuser
                                          : (w_row == RW'(2) && w_col == CW'(2));
    w_meta.eol  = w_col_last;
    w_meta.eof  = w_row_last && w_col_last;
    w_meta.mode = w_mode;
  end

  // Line buffers are read-before-write: lb0 holds row r-1, lb1 holds row r-2.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_col] <= s_axis_tdata;
      r_lb1[w_col] <= r_lb0[w_col];
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_lb1[w_col];
      r_win[1][2] <= r_lb0[w_col];
      r_win[2][2] <= s_axis_tdata;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [2:0][2:0][PW-1:0] w_kwin;
    always_comb begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_kwin[r][c] = r_win[r][c][k*PW +: PW];
    end
    gauss3x3_kernel #(.PW(PW)) u_kernel (
      .i_win (w_kwin),
      .o_pix (w_blur[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= MODE_BLUR;
      r_sof_err <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_meta <= '0;
      r_m_valid <= 1'b0;
      r_m_tdata <= '0;
      r_m_tuser <= 1'b0;
      r_m_tlast <= 1'b0;
      r_m_eof   <= 1'b0;
    end else begin
      if (w_acc) begin
        if (s_axis_tuser) begin
          r_mode <= w_mode;
          if (r_row != '0 || r_col != '0)
            r_sof_err <= 1'b1;
        end
        r_col <= w_col_last ? '0 : w_col + 1'b1;
        if (w_col_last)
          r_row <= w_row_last ? '0 : w_row + 1'b1;
        else
          r_row <= w_row;
      end
      // Both stages move together so a stalled output freezes the whole pipe.
      if (w_adv) begin
        r_s1_vld  <= w_acc && w_emit;
        r_s1_meta <= w_meta;
        r_m_valid <= r_s1_vld;
        r_m_tuser <= r_s1_vld && r_s1_meta.sof;
        r_m_tlast <= r_s1_vld && r_s1_meta.eol;
        r_m_eof   <= r_s1_vld && r_s1_meta.eof;
        if (r_s1_vld)
          r_m_tdata <= (r_s1_meta.mode == MODE_BLUR) ? w_blur : r_win[2][2];
      end
    end
  end

  assign s_axis_tready = w_adv && !rst;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign frame_done    = r_m_valid && m_axis_tready && r_m_eof && !rst;
  assign sof_err       = r_sof_err;

endmodule

// File: tb/tb_gauss3x3_stream.sv
// Randomised stream bench for gauss3x3_stream with an image-level reference model.
module tb_gauss3x3_stream;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int CH = 2;
  localparam int PW = 8;
  localparam int DW = CH * PW;

  logic          clk, rst, mode;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tuser, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic          frame_done, sof_err;

  gauss3x3_stream #(.IMG_W(W), .IMG_H(H), .CH(CH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .frame_done(frame_done), .sof_err(sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit sof, eol, eof;
    int acc, cr, cc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] cap [H][W];
  int  n_chk = 0, n_err = 0;
  int  samp = 0, n_out = 0, fd_cnt = 0, stall_req = 0;
  int  mrow = 0, mcol = 0;
  bit  mmode = 1'b1, exp_sof_err = 1'b0, after_rst = 1'b0;
  bit  lat_chk = 1'b0, rdy_rand = 1'b0;
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_user, prev_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference blur straight from the stored image: weights (2-|dr|)*(2-|dc|).
  function automatic logic [DW-1:0] blur_at(input int r, input int c);
    logic [DW-1:0] res;
    int s, wr, wc;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          wr = 2 - ((dr < 0) ? -dr : dr);
          wc = 2 - ((dc < 0) ? -dc : dc);
          s += wr * wc * int'(img[r+dr][c+dc][k*PW +: PW]);
        end
      res[k*PW +: PW] = PW'((s + 8) / 16);
    end
    return res;
  endfunction

  task automatic model_accept();
    exp_t e;
    if (s_axis_tuser) begin
      if (mrow != 0 || mcol != 0) exp_sof_err = 1'b1;
      mrow = 0; mcol = 0; mmode = mode;
    end
    img[mrow][mcol] = s_axis_tdata;
    e.acc = samp;
    e.eol = (mcol == W-1);
    e.eof = (mrow == H-1) && (mcol == W-1);
    if (!mmode) begin
      e.data = s_axis_tdata; e.sof = s_axis_tuser; e.cr = mrow; e.cc = mcol;
      q.push_back(e);
    end else if (mrow >= 2 && mcol >= 2) begin
      e.data = blur_at(mrow-1, mcol-1); e.sof = (mrow == 2 && mcol == 2);
      e.cr = mrow-1; e.cc = mcol-1;
      q.push_back(e);
    end
    mcol++;
    if (mcol == W) begin
      mcol = 0; mrow++;
      if (mrow == H) mrow = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    samp++;
    if (rst) begin
      chk("s_tready_in_rst", s_axis_tready, 0);
      q.delete();
      mrow = 0; mcol = 0; mmode = 1'b1; exp_sof_err = 1'b0;
      after_rst = 1'b1; prev_stall = 1'b0;
    end else begin
      if (after_rst) begin
        chk("tvalid_after_rst", m_axis_tvalid, 0);
        after_rst = 1'b0;
      end
      chk("s_tready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
      chk("sof_err", sof_err, exp_sof_err);
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, prev_data);
        chk("stall_user", {m_axis_tuser, m_axis_tlast}, {prev_user, prev_last});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", m_axis_tdata, 32'hDEAD);
        end else begin
          e = q.pop_front();
          chk("out_data", m_axis_tdata, e.data);
          chk("out_tuser", m_axis_tuser, e.sof);
          chk("out_tlast", m_axis_tlast, e.eol);
          chk("frame_done", frame_done, e.eof);
          if (lat_chk) chk("latency", samp - e.acc, 2);
          cap[e.cr][e.cc] = m_axis_tdata;
          n_out++;
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      if (frame_done) fd_cnt++;
      if (s_axis_tvalid && s_axis_tready) model_accept();
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_req > 0) begin
        m_axis_tready = 1'b0;
        stall_req--;
      end else begin
        m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic send_pix(input logic [DW-1:0] d, input bit sof, input bit md, input int gap_pct);
    if ($urandom_range(0, 99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata = d; s_axis_tuser = sof; s_axis_tvalid = 1'b1;
    mode = sof ? md : 1'($urandom_range(0, 1));
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        break;
      end
      if (t > 300) begin
        chk("accept_timeout", t, 0);
        break;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
  endtask

  // kind: 0 constant 100, 1 impulse at (2,2), 2 ramp, 3 random. n_pix < W*H sends a partial frame.
  task automatic send_frame(input bit md, input int kind, input int gap_pct,
                            input int stall_at, input int n_pix);
    logic [DW-1:0] d;
    int idx;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        idx = r * W + c;
        if (idx < n_pix) begin
          case (kind)
            0: d = {8'd100, 8'd100};
            1: d = (r == 2 && c == 2) ? 16'hFFFF : 16'h0000;
            2: d = {8'(255 - idx), 8'(idx)};
            default: d = 16'($urandom);
          endcase
          if (idx == stall_at) stall_req = 5;
          send_pix(d, idx == 0, md, gap_pct);
        end
      end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_axis_tvalid && stall_req == 0) done = 1'b1;
    end
    chk("drain_queue_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic new_frame();
    n_out = 0; fd_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) cap[r][c] = 16'hBEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_tready", s_axis_tready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", s_axis_tready, 1);
    @(posedge clk); #1;

    // Constant frame: every cropped output must equal the input level.
    lat_chk = 1'b1;
    new_frame();
    send_frame(1'b1, 0, 0, -1, W*H);
    drain();
    chk("const_out_count", n_out, (W-2)*(H-2));
    chk("const_frame_done", fd_cnt, 1);
    for (int r = 1; r <= H-2; r++)
      for (int c = 1; c <= W-2; c++) chk("const_value", cap[r][c], 16'h6464);

    // Impulse: 255 at (2,2) spreads as 64 / 32 / 16, zero beyond.
    for (int pass = 0; pass < 2; pass++) begin
      lat_chk = (pass == 0);
      new_frame();
      send_frame(1'b1, 1, 0, (pass == 1) ? 15 : -1, W*H);
      drain();
      chk("imp_out_count", n_out, (W-2)*(H-2));
      chk("imp_frame_done", fd_cnt, 1);
      chk("imp_centre", cap[2][2], 16'h4040);
      chk("imp_up", cap[1][2], 16'h2020);
      chk("imp_down", cap[3][2], 16'h2020);
      chk("imp_left", cap[2][1], 16'h2020);
      chk("imp_right", cap[2][3], 16'h2020);
      chk("imp_corner_ul", cap[1][1], 16'h1010);
      chk("imp_corner_dr", cap[3][3], 16'h1010);
      chk("imp_far", cap[2][4], 16'h0000);
    end

    // Bypass ramp with input gaps: unchanged data, fixed latency.
    lat_chk = 1'b1;
    new_frame();
    send_frame(1'b0, 2, 25, -1, W*H);
    drain();
    chk("byp_out_count", n_out, W*H);
    chk("byp_frame_done", fd_cnt, 1);
    chk("byp_pix_0_0", cap[0][0], 16'hFF00);
    chk("byp_pix_4_5", cap[4][5], {8'd226, 8'd29});

    // Misplaced start-of-frame at (1,2), then a full random frame.
    lat_chk = 1'b0;
    rdy_rand = 1'b1;
    send_frame(1'b1, 3, 20, -1, W + 2);
    new_frame();
    send_frame(1'b1, 3, 20, -1, W*H);
    drain();
    chk("sof_err_sticky", sof_err, 1);
    chk("restart_out_count", n_out, (W-2)*(H-2));
    chk("restart_frame_done", fd_cnt, 1);

    // Reset mid-frame, then clean frames with random mode and backpressure.
    send_frame(1'b1, 3, 10, -1, 20);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("sof_err_cleared", sof_err, 0);
    for (int f = 0; f < 4; f++) begin
      bit md;
      md = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      new_frame();
      send_frame(md, 3, 20, -1, W*H);
      drain();
      chk("rand_out_count", n_out, md ? (W-2)*(H-2) : W*H);
      chk("rand_frame_done", fd_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
